// File: rtl/step_sched_pkg.sv
// Shared constants and types for the drum-machine step scheduler.
package drum_pkg;
   localparam int STEPS    = 32;
   localparam int SAMPLE_W = 3;
   localparam int LEN_W    = 10;
   localparam int MAPS     = 4;
   localparam int STEP_W   = $clog2(STEPS);
   localparam int MAP_W    = $clog2(MAPS);
   // One spare bit so the swung (longer) step length never overflows.
   localparam int CNT_W    = LEN_W + 1;
   localparam logic [SAMPLE_W-1:0] REST_CODE = '0;

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, RUN} state_t;
endpackage

// File: rtl/step_sched_if.sv
// Pattern-store read port: one-cycle request, data returned later with a valid strobe.
interface step_sched_if;
   import drum_pkg::*;

   logic                rd_req;
   logic [MAP_W-1:0]    rd_map;
   logic [STEP_W-1:0]   rd_step;
   logic [SAMPLE_W-1:0] rd_data;
   logic                rd_vld;

   modport master (output rd_req, rd_map, rd_step, input rd_data, rd_vld);
   modport slave  (input rd_req, rd_map, rd_step, output rd_data, rd_vld);
endinterface

// File: rtl/step_sched_timer.sv
// Step timer: counts 1 ms ticks and flags when the current step is due to end.
// Optional swing timing is built when STEP_SCHED_SWING_EN is defined.
module step_timer
   import drum_pkg::*;
(
   input  logic             clk,
   input  logic             nrst,
   input  logic             clr,
   input  logic             en,
   input  logic             step_odd,
   input  logic             tick_1ms,
   input  logic [LEN_W-1:0] step_len,
   output logic             due
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] eff_len, tgt_len;

   always_comb begin
      eff_len = (step_len == '0) ? CNT_W'(1) : CNT_W'(step_len);
`ifdef STEP_SCHED_SWING_EN
      // Long even steps, short odd steps; a pair keeps the nominal duration.
      if (step_odd) begin
         tgt_len = eff_len - (eff_len >> 2);
         if (tgt_len == '0) tgt_len = CNT_W'(1);
      end else begin
         tgt_len = eff_len + (eff_len >> 2);
      end
`else
      tgt_len = eff_len;
`endif
   end

`ifndef STEP_SCHED_SWING_EN
   logic unused_step_odd;
   assign unused_step_odd = step_odd;
`endif

   // >= rather than == so a shrinking step_len never overruns.
   assign due = tick_1ms && (cnt_q >= tgt_len - CNT_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) cnt_d = '0;
      else if (en && tick_1ms && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/step_sched.sv
// Step scheduler: fetches each pattern step, fires triggers, and owns play/stop
// and bar-aligned pattern switching. Optional swing: STEP_SCHED_SWING_EN.
module step_sched
   import drum_pkg::*;
(
   input  logic                clk,
   input  logic                nrst,
   input  logic                tick_1ms,
   input  logic [LEN_W-1:0]    step_len,
   input  logic                play,
   input  logic                stop,
   input  logic [MAP_W-1:0]    map_sel,
   input  logic                map_sel_vld,
   step_sched_if.master        rd,
   output logic                trig,
   output logic [SAMPLE_W-1:0] trig_sample,
   output logic [STEP_W-1:0]   step_idx,
   output logic [MAP_W-1:0]    cur_map,
   output logic                running,
   output logic                bar_start
);
   state_t              state_q;
   logic [STEP_W-1:0]   step_idx_q, step_idx_d;
   logic [MAP_W-1:0]    cur_map_q, pend_q;
   logic [SAMPLE_W-1:0] sample_q;
   logic                rd_req_q, trig_q, bar_q;
   logic                due, tmr_clr, tmr_en;

   assign step_idx_d = step_idx_q + STEP_W'(1);
   // Ticks keep counting through FETCH/WAIT so fetch latency never shifts the grid.
   assign tmr_en  = (state_q != IDLE);
   assign tmr_clr = (state_q == IDLE) || ((state_q == RUN) && due);

   step_timer u_timer (
      .clk      (clk),
      .nrst     (nrst),
      .clr      (tmr_clr),
      .en       (tmr_en),
      .step_odd (step_idx_q[0]),
      .tick_1ms (tick_1ms),
      .step_len (step_len),
      .due      (due)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         step_idx_q <= '0;
         cur_map_q  <= '0;
         pend_q     <= '0;
         sample_q   <= '0;
         rd_req_q   <= 1'b0;
         trig_q     <= 1'b0;
         bar_q      <= 1'b0;
      end else begin
         rd_req_q <= 1'b0;
         trig_q   <= 1'b0;
         bar_q    <= 1'b0;
         if (map_sel_vld) pend_q <= map_sel;

         if (stop && (state_q != IDLE)) begin
            state_q    <= IDLE;
            step_idx_q <= '0;
         end else begin
            case (state_q)
               IDLE: if (play && !stop) begin
                  state_q    <= FETCH;
                  step_idx_q <= '0;
                  cur_map_q  <= pend_q;
                  rd_req_q   <= 1'b1;
                  bar_q      <= 1'b1;
               end
               FETCH: state_q <= WAIT;
               WAIT: if (rd.rd_vld) begin
                  state_q <= RUN;
                  if (rd.rd_data != REST_CODE) begin
                     trig_q   <= 1'b1;
                     sample_q <= rd.rd_data;
                  end
               end
               RUN: if (due) begin
                  state_q    <= FETCH;
                  step_idx_q <= step_idx_d;
                  rd_req_q   <= 1'b1;
                  // Pattern switches only at the bar wrap.
                  if (step_idx_d == '0) begin
                     cur_map_q <= pend_q;
                     bar_q     <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rd.rd_req   = rd_req_q;
   assign rd.rd_map   = cur_map_q;
   assign rd.rd_step  = step_idx_q;
   assign trig        = trig_q;
   assign trig_sample = sample_q;
   assign step_idx    = step_idx_q;
   assign cur_map     = cur_map_q;
   assign running     = (state_q != IDLE);
   assign bar_start   = bar_q;
endmodule

// File: tb/tb_step_sched.sv
// Self-checking bench for step_sched: directed scenarios plus randomized traffic,
// all checked each cycle against a behavioural model of the scheduler.
module tb_step_sched;
   import drum_pkg::*;

   logic                clk = 1'b0;
   logic                nrst, tick_1ms, play, stop, map_sel_vld;
   logic [LEN_W-1:0]    step_len;
   logic [MAP_W-1:0]    map_sel;
   logic                trig, running, bar_start;
   logic [SAMPLE_W-1:0] trig_sample;
   logic [STEP_W-1:0]   step_idx;
   logic [MAP_W-1:0]    cur_map;

   step_sched_if rd_if ();

   step_sched dut (
      .clk(clk), .nrst(nrst), .tick_1ms(tick_1ms), .step_len(step_len),
      .play(play), .stop(stop), .map_sel(map_sel), .map_sel_vld(map_sel_vld),
      .rd(rd_if), .trig(trig), .trig_sample(trig_sample), .step_idx(step_idx),
      .cur_map(cur_map), .running(running), .bar_start(bar_start)
   );

   always #5 clk = ~clk;

`ifdef STEP_SCHED_SWING_EN
   localparam int A_EV = 5, A_OD = 3, F_EV = 10, F_OD = 6;
`else
   localparam int A_EV = 4, A_OD = 4, F_EV = 8, F_OD = 8;
`endif
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   int n_chk = 0, n_fail = 0;
   int pat [MAPS][STEPS];

   // model state: phase 0=idle 1=fetch 2=wait 3=run
   int m_phase = 0, m_cnt = 0, m_step = 0, m_map = 0, m_pend = 0, m_samp = 0;
   int m_trig = 0, m_req = 0, m_bar = 0;

   int rq_due[$], rq_dat[$];
   int lg_req_tick[$], lg_req_step[$], lg_req_map[$], lg_trig_samp[$], lg_trig_step[$];
   int lg_bar;

   int cyc = 0, tick_no = 0, tick_per = 4, lat = 1;
   bit rnd = 0;
   bit g_play = 0, g_stop = 0, g_msv = 0;
   int g_ms = 0, g_len = 4;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic int tgt(input int s, input int len);
      int e, q, t;
      e = (len == 0) ? 1 : len;
      q = 0;
`ifdef STEP_SCHED_SWING_EN
      q = e / 4;
`endif
      t = (s % 2 == 1) ? e - q : e + q;
      if (t < 1) t = 1;
      return t;
   endfunction

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic model_step(input int tk, input int pl, input int sp, input int msv,
                             input int ms, input int len, input int vld, input int dat);
      int op, oc, os, opd;
      bit bdy;
      op = m_phase; oc = m_cnt; os = m_step; opd = m_pend;
      bdy = (op == 3) && (tk != 0) && (oc >= tgt(os, len) - 1);
      m_trig = 0; m_req = 0; m_bar = 0;
      if (msv != 0) m_pend = ms;
      if (op != 0 && sp != 0) begin
         m_phase = 0; m_step = 0; m_cnt = 0;
      end else if (op == 0) begin
         m_cnt = 0;
         if (pl != 0 && sp == 0) begin
            m_phase = 1; m_step = 0; m_map = opd; m_req = 1; m_bar = 1;
         end
      end else if (op == 1) begin
         m_phase = 2; m_cnt = sat(oc + tk);
      end else if (op == 2) begin
         m_cnt = sat(oc + tk);
         if (vld != 0) begin
            m_phase = 3;
            if (dat != 0) begin m_trig = 1; m_samp = dat; end
         end
      end else if (bdy) begin
         m_cnt = 0; m_step = (os + 1) % STEPS; m_req = 1; m_phase = 1;
         if (m_step == 0) begin m_map = opd; m_bar = 1; end
      end else begin
         m_cnt = sat(oc + tk);
      end
   endtask

   task automatic cycle();
      int tk, v, d, l;
      chk("running", running, (m_phase != 0) ? 1 : 0);
      chk("rd_req", rd_if.rd_req, m_req);
      if (m_req != 0) begin
         chk("rd_map", rd_if.rd_map, m_map);
         chk("rd_step", rd_if.rd_step, m_step);
      end
      chk("trig", trig, m_trig);
      chk("trig_sample", trig_sample, m_samp);
      chk("step_idx", step_idx, m_step);
      chk("cur_map", cur_map, m_map);
      chk("bar_start", bar_start, m_bar);
      if (rd_if.rd_req) begin
         lg_req_tick.push_back(tick_no);
         lg_req_step.push_back(int'(rd_if.rd_step));
         lg_req_map.push_back(int'(rd_if.rd_map));
      end
      if (bar_start) lg_bar++;
      if (trig) begin
         lg_trig_samp.push_back(int'(trig_sample));
         lg_trig_step.push_back(int'(step_idx));
      end
      if (rnd) begin
         g_play = ($urandom_range(39) == 0);
         g_stop = ($urandom_range(149) == 0);
         g_msv  = ($urandom_range(59) == 0);
         g_ms   = $urandom_range(MAPS - 1);
         if ($urandom_range(199) == 0) g_len = $urandom_range(6);
         tk = ($urandom_range(2) == 0) ? 1 : 0;
      end else begin
         tk = (cyc % tick_per == 0) ? 1 : 0;
      end
      tick_no += tk;
      tick_1ms = tk[0]; play = g_play; stop = g_stop; map_sel_vld = g_msv;
      map_sel = g_ms[MAP_W-1:0]; step_len = g_len[LEN_W-1:0];
      v = 0; d = 0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
         v = 1; d = rq_dat.pop_front(); void'(rq_due.pop_front());
      end else if (rnd && (m_phase == 0 || m_phase == 3) && $urandom_range(29) == 0) begin
         v = 1; d = $urandom_range(7);
      end
      rd_if.rd_vld = v[0]; rd_if.rd_data = d[SAMPLE_W-1:0];
      model_step(tk, g_play, g_stop, g_msv, g_ms, g_len, v, d);
      g_play = 0; g_stop = 0; g_msv = 0;
      if (m_req != 0) begin
         l = rnd ? $urandom_range(5, 1) : lat;
         rq_due.push_back(cyc + 1 + l);
         rq_dat.push_back(pat[m_map][m_step]);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_logs();
      lg_req_tick.delete(); lg_req_step.delete(); lg_req_map.delete();
      lg_trig_samp.delete(); lg_trig_step.delete(); lg_bar = 0;
   endtask

   task automatic start_play(input int mp);
      clear_logs();
      g_ms = mp; g_msv = 1; cycle();
      g_play = 1; cycle();
   endtask

   task automatic stop_all();
      g_stop = 1; cycle();
      repeat (10) cycle();
   endtask

   task automatic run_reqs(input int n, input string nm);
      int b;
      b = 3000;
      while (lg_req_step.size() < n && b > 0) begin cycle(); b--; end
      chk({nm, "_reqs"}, lg_req_step.size(), n);
   endtask

   task automatic check_intervals(input string nm, input int n, input int ev, input int od);
      int bad;
      bad = 0;
      for (int i = 1; i < n && i < lg_req_tick.size(); i++)
         if (lg_req_tick[i] - lg_req_tick[i-1] != (((i - 1) % 2 == 0) ? ev : od)) bad++;
      chk({nm, "_bad_intervals"}, bad, 0);
   endtask

   initial begin
      int bad, t0;
      for (int m = 0; m < MAPS; m++)
         for (int s = 0; s < STEPS; s++) pat[m][s] = (m == 1) ? 0 : ((m == 0) ? 5 : 6);
      pat[1][0] = 3; pat[1][3] = 7;
      nrst = 1'b1; tick_1ms = 0; play = 0; stop = 0; map_sel = '0; map_sel_vld = 0;
      step_len = 10'd4; rd_if.rd_vld = 0; rd_if.rd_data = '0;
      #2 nrst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_running", running, 0);
      chk("rst_step_idx", step_idx, 0);
      chk("rst_cur_map", cur_map, 0);
      chk("rst_trig_sample", trig_sample, 0);
      chk("rst_rd_req", rd_if.rd_req, 0);
      chk("rst_trig_bar", int'(trig) + int'(bar_start), 0);
      nrst = 1'b1;

      // A: steady playback of an all-5 pattern over a full bar
      g_len = 4; tick_per = 4; lat = 1;
      start_play(0);
      run_reqs(34, "A");
      check_intervals("A", 34, A_EV, A_OD);
      bad = 0;
      for (int i = 0; i < lg_req_step.size(); i++) if (lg_req_step[i] != i % 32) bad++;
      chk("A_step_seq", bad, 0);
      chk("A_bar_count", lg_bar, 2);
      bad = 0;
      foreach (lg_trig_samp[i]) if (lg_trig_samp[i] != 5) bad++;
      chk("A_samples_5", bad, 0);
      chk("A_trig_ge33", (lg_trig_samp.size() >= 33) ? 1 : 0, 1);
      stop_all();

      // B: rests suppress triggers
      start_play(1);
      run_reqs(5, "B");
      chk("B_trig_count", lg_trig_samp.size(), 2);
      chk("B_samp0", (lg_trig_samp.size() > 0) ? lg_trig_samp[0] : -1, 3);
      chk("B_samp1", (lg_trig_samp.size() > 1) ? lg_trig_samp[1] : -1, 7);
      chk("B_step1", (lg_trig_step.size() > 1) ? lg_trig_step[1] : -1, 3);
      stop_all();

      // C: pattern switch deferred to the bar wrap
      g_len = 1; tick_per = 3;
      start_play(0);
      run_reqs(11, "C1");
      g_ms = 2; g_msv = 1;
      run_reqs(33, "C2");
      bad = 0;
      for (int i = 0; i < 32 && i < lg_req_map.size(); i++) if (lg_req_map[i] != 0) bad++;
      chk("C_map0_bar", bad, 0);
      chk("C_map2_wrap", (lg_req_map.size() > 32) ? lg_req_map[32] : -1, 2);
      chk("C_cur_map", cur_map, 2);
      stop_all();

      // D: stop during WAIT, late data ignored; play+stop from IDLE
      g_len = 4; tick_per = 4; lat = 6;
      start_play(0);
      run_reqs(1, "D");
      g_stop = 1; cycle();
      repeat (10) cycle();
      chk("D_running", running, 0);
      chk("D_step_idx", step_idx, 0);
      chk("D_no_trig", lg_trig_samp.size(), 0);
      g_play = 1; g_stop = 1; cycle(); cycle();
      chk("D_still_idle", running, 0);
      chk("D_no_req", lg_req_step.size(), 1);

      // E: zero length -> one step per tick; shrink 10->3 at count 6
      g_len = 0; lat = 1;
      start_play(0);
      run_reqs(6, "E1");
      check_intervals("E1", 6, 1, 1);
      stop_all();
      g_len = 10;
      start_play(0);
      run_reqs(1, "E2");
      t0 = lg_req_tick[0];
      while (tick_no - t0 < 6) cycle();
      g_len = 3;
      run_reqs(2, "E3");
      chk("E_shrink_interval", lg_req_tick[1] - lg_req_tick[0], 7);
      stop_all();

      // F: slow fetch loses no steps; then swing/nominal timing
      g_len = 2; tick_per = 2; lat = 6;
      start_play(0);
      run_reqs(6, "F1");
      bad = 0;
      for (int i = 0; i < lg_req_step.size(); i++) if (lg_req_step[i] != i) bad++;
      chk("F_no_skip", bad, 0);
      stop_all();
      g_len = 8; lat = 1;
      start_play(0);
      run_reqs(5, "F2");
      check_intervals("F2", 5, F_EV, F_OD);
      stop_all();

      // R: randomized traffic against the model
      for (int m = 0; m < MAPS; m++)
         for (int s = 0; s < STEPS; s++) pat[m][s] = $urandom_range(7);
      rnd = 1;
      repeat (4000) cycle();
      rnd = 0;
      stop_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
